// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with valid/ready output, parity/framing flags and sticky overrun.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO instead of a single holding register.
module uart_rx_oversampled #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int FW = DATA_BITS + 2;

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("TICK_DIV must be >= 1");
        end
        if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_os
            $error("OVERSAMPLE must be even and >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
            $error("unsupported frame format");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 rx_m, rx_s, tick, bit_end, commit;
    logic [TW-1:0]        tick_cnt;
    state_t               state, state_d;
    logic [SW-1:0]        sample_cnt, sample_d;
    logic [3:0]           bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 pop, full, accept;

    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {rx, rx_m};

    assign tick = enable && tick_cnt == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) tick_cnt <= '0;
        else tick_cnt <= (!enable || tick) ? '0 : tick_cnt + TW'(1);

    assign bit_end = sample_cnt == SW'(OVERSAMPLE - 1);
    assign busy    = state != IDLE;

    always_comb begin
        state_d  = state;
        sample_d = sample_cnt;
        bit_d    = bit_cnt;
        shreg_d  = shreg;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        commit   = 1'b0;
        if (tick) begin
            sample_d = sample_cnt + SW'(1);
            case (state)
                IDLE: begin
                    sample_d = '0;
                    if (!rx_s) begin
                        state_d = START;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                START: if (sample_cnt == SW'(OVERSAMPLE / 2 - 1)) begin
                    state_d  = rx_s ? IDLE : DATA;
                    sample_d = '0;
                    bit_d    = '0;
                end
                DATA: if (bit_end) begin
                    shreg_d  = {rx_s, shreg[DATA_BITS-1:1]};
                    sample_d = '0;
                    bit_d    = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state_d = PARITY_MODE != 0 ? PARITY : STOP;
                        bit_d   = '0;
                    end
                end
                PARITY: if (bit_end) begin
                    perr_d   = (^shreg ^ rx_s) != (PARITY_MODE == 2);
                    state_d  = STOP;
                    sample_d = '0;
                end
                STOP: if (bit_end) begin
                    // sampled mid stop bit, so returning to IDLE here catches the next start edge
                    ferr_d   = ferr_q | !rx_s;
                    sample_d = '0;
                    bit_d    = bit_cnt + 4'd1;
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        commit  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst || !enable) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state      <= state_d;
            sample_cnt <= sample_d;
            bit_cnt    <= bit_d;
            shreg      <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end

    assign pop    = data_valid && data_ready;
    assign accept = commit && (!full || pop);

    always_ff @(posedge clk or posedge rst)
        if (rst || !enable) overrun <= 1'b0;
        else if (commit && !accept) overrun <= 1'b1;

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    assign full       = count == (PW + 1)'(FIFO_DEPTH);
    assign data_valid = count != '0;
    assign {data_out, parity_error, framing_error} = data_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {shreg, perr_q, ferr_d};

    always_ff @(posedge clk or posedge rst)
        if (rst || !enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(accept);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW + 1)'(accept) - (PW + 1)'(pop);
        end
`else
    logic [FW-1:0] hold;
    logic          valid_q;

    assign full       = valid_q;
    assign data_valid = valid_q;
    assign {data_out, parity_error, framing_error} = hold;

    always_ff @(posedge clk or posedge rst)
        if (rst || !enable) begin
            hold    <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) hold <= {shreg, perr_q, ferr_d};
            valid_q <= accept || (valid_q && !pop);
        end
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: randomized 8E2 frames against a frame-level scoreboard model.
module tb_uart_rx_oversampled;
    localparam int PARITY_MODE = 1;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {logic [7:0] d; logic p; logic f;} frame_t;

    logic       clk = 0, rst = 1, enable = 1, rx = 1, data_ready = 0;
    logic [7:0] data_out;
    logic       data_valid, parity_error, framing_error, overrun, busy;
    int         errors = 0, checks = 0;
    bit         ready_mode = 1, exp_ovr = 0;
    frame_t     sb[$];

    uart_rx_oversampled #(
        .CLOCK_FREQ(1600), .BAUD_RATE(100), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY_MODE(PARITY_MODE), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx(rx), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .parity_error(parity_error),
        .framing_error(framing_error), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // model: a frame is kept if there is room when it completes, otherwise overrun is expected
    task automatic send(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        bit odd;
        frame_t e;
        odd = ($countones({d, pbit}) % 2) == 1;
        e.d = d;
        e.p = PARITY_MODE == 1 ? odd : PARITY_MODE == 2 ? !odd : 1'b0;
        e.f = !s1 || !s2;
        @(posedge clk);
        #1;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(pbit);
        bit_out(s1);
        if (sb.size() < DEPTH) sb.push_back(e);
        else exp_ovr = 1;
        bit_out(s2);
        rx = 1;
        repeat (32) @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("drain", sb.size(), 0);
        sb.delete();
    endtask

    always begin
        @(posedge clk);
        #1 data_ready = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    initial begin
        logic       hold_p = 0;
        logic [7:0] hold_d = 0;
        frame_t     e;
        forever begin
            @(negedge clk);
            if (rst || !enable) hold_p = 0;
            else begin
                if (hold_p && data_valid) chk("stable", data_out, hold_d);
                if (data_valid && data_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", data_out);
                    end else begin
                        e = sb.pop_front();
                        chk("data", data_out, e.d);
                        chk("parity_error", parity_error, e.p);
                        chk("framing_error", framing_error, e.f);
                        chk("overrun", overrun, exp_ovr);
                    end
                end
                hold_p = data_valid && !data_ready;
                hold_d = data_out;
            end
        end
    end

    initial begin
        bit busy_seen, valid_seen;
        logic [7:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_perr", parity_error, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 0;
        repeat (20) @(posedge clk);

        send(8'hA7, 1'b0, 1'b1, 1'b1); drain();
        send(8'hA7, 1'b1, 1'b1, 1'b1); drain();
        send(8'h3C, 1'b0, 1'b1, 1'b0); drain();
        send(8'h55, 1'b0, 1'b0, 1'b1); drain();

        @(posedge clk);
        #1 rx = 0;
        repeat (4) @(posedge clk);
        #1 rx = 1;
        busy_seen = 0;
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            busy_seen |= busy;
            valid_seen |= data_valid;
        end
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_valid", valid_seen, 0);
        chk("glitch_idle", busy, 0);

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send(d, (^d) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0);
            drain();
        end

        ready_mode = 0;
        repeat (2) @(posedge clk);
        for (int i = 1; i <= DEPTH + 1; i++) send(8'(i * 8'h11), ^(8'(i * 8'h11)), 1'b1, 1'b1);
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        chk("overrun_head", data_out, 8'h11);
        ready_mode = 1;
        drain();
        @(negedge clk);
        chk("overrun_sticky", overrun, 1);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send(8'h0F, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("held_valid", data_valid, 1);
        @(posedge clk);
        #1 enable = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("disable_valid", data_valid, 0);
        chk("disable_ovr", overrun, 0);
        sb.delete();
        exp_ovr = 0;
        @(posedge clk);
        #1 enable = 1;
        ready_mode = 1;
        repeat (10) @(posedge clk);

        @(posedge clk);
        #1;
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b0);
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", data_valid, 0);
        rx = 1;
        @(posedge clk);
        #1 rst = 0;
        repeat (32) @(posedge clk);
        send(8'h42, 1'b0, 1'b1, 1'b1);
        drain();
        repeat (20) @(posedge clk);
        chk("final_ovr", overrun, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
